nv_ram_rws_param: RTL and testbench
===================================

Name: nv_ram_rws_param

Overview:
- Parametrised successor to the fixed-size NVDLA register-file RAMs: one read port, one write port, width and depth set by parameters.
- Adds per-lane write mask, mask-aware read-during-write bypass, a read-valid flag and a hardware clear sequencer.
- Used by CACC/CDMA buffers that need sizes other than 32x544, plus a way to scrub contents without a host write loop.

Parameters:
- DW, 544, data width in bits.
- DEPTH, 32, number of entries; need not be a power of 2.
- AW, 5, address width; requires 2^AW >= DEPTH.
- MASK_GRAN, 32, bits per write-mask lane; DW must be a multiple of MASK_GRAN.
- MW, DW/MASK_GRAN (17), write-mask width (derived).

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ra  input  AW  read address.
- re  input  1  read enable.
- dout  output  DW  read data.
- dout_vld  output  1  read data valid.
- wa  input  AW  write address.
- we  input  1  write enable.
- wmask  input  MW  write lane mask; bit k covers di[k*MASK_GRAN +: MASK_GRAN].
- di  input  DW  write data.
- clr_req  input  1  single-cycle clear request.
- clr_busy  output  1  clear sequence in progress.
- pwrbus_ram_pd  input  32  power-down bus; carried for integration, no functional effect.

Behaviour:
- Reset: dout=0, dout_vld=0, clr_busy=0, FSM=IDLE, clear counter=0. Storage array is not reset; contents are undefined until written or cleared.
- Write (we=1, FSM=IDLE, wa<DEPTH): at the clk edge, only lanes with wmask[k]=1 update; other lanes hold. wmask=0 is a legal no-op.
- Write with wa>=DEPTH: dropped silently.
- Read, latency 1: re=1 at edge N gives dout/dout_vld at edge N. dout_vld=1 for exactly the cycles following an re=1 edge; otherwise 0.
- Hold: when re=0, dout holds its last value and dout_vld=0.
- Read with ra>=DEPTH: dout=0, dout_vld=1.
- Bypass (re & we & ra==wa, ra<DEPTH, IDLE): dout = masked merge: new di in lanes with wmask=1, old entry content in the other lanes. Array updates as a normal write.
- Different-address read and write in the same cycle are independent.
- Clear FSM, IDLE->CLEAR:
  - Trigger: clr_req=1 in IDLE.
  - clr_busy rises the next cycle.
  - Counter runs 0..DEPTH-1, zeroing one entry per cycle.
  - After writing entry DEPTH-1: CLEAR->IDLE; clr_busy falls the next cycle.
  - clr_busy is high for exactly DEPTH cycles.
- While CLEAR:
  - External we is ignored.
  - re=1 returns dout=0, dout_vld=1.
  - clr_req is ignored.
- clr_req and we in the same IDLE cycle: the write is performed, then the clear wipes it.
- Reset mid-clear: FSM returns to IDLE, clr_busy=0, array partially cleared (undefined).

Optional Feature:
- Macro: NV_RAM_RWS_OUT_FLOP_EN.
- Defined: adds an output register stage.
  - Read latency 2; dout_vld is delayed with the data.
  - The stage resets to 0.
  - Hold behaviour applies at the final stage.
  - Bypass result is captured at stage 1 and carried through.
- Undefined: latency 1 as above.

Test Plan:
- Write/read: reset, write wa=3 di=all-0xA5 wmask=all-1; next cycle re ra=3 -> dout=0xA5.. at edge+1, dout_vld=1 for one cycle; then re=0 -> dout holds, dout_vld=0.
- Masked write: entry 5 = all-1s; write di=0, wmask=17'h00001 -> read 5 gives bits[31:0]=0, bits[543:32]=all-1s.
- Bypass: entry 7 = 0x1111..; same cycle we wa=7 di=0x2222.. wmask=17'h10000 plus re ra=7 -> dout top 32 bits=0x22222222, rest 0x11111111; a later read matches.
- Out of range: DEPTH=20, AW=5. Write wa=25 then read ra=25 -> dout=0, dout_vld=1; entries 0..19 unchanged.
- Clear:
  - Fill all 32 entries, pulse clr_req -> clr_busy high exactly 32 cycles.
  - we during busy ignored; re during busy returns 0.
  - Afterwards all entries read 0.
  - Apply rst mid-clear -> clr_busy=0 immediately.
- With NV_RAM_RWS_OUT_FLOP_EN: repeat write/read -> data and dout_vld appear 2 edges after re; dout=0 after reset.

Source files
------------

// File: rtl/nv_ram_rws_param.sv
// rtl/nv_ram_rws_param.sv - parametrised 1R1W register-file RAM with lane mask, bypass and clear sequencer
// Optional output register stage: define NV_RAM_RWS_OUT_FLOP_EN.
module nv_ram_rws_param #(
  parameter int DW        = 544,
  parameter int DEPTH     = 32,
  parameter int AW        = 5,
  parameter int MASK_GRAN = 32,
  parameter int MW        = DW / MASK_GRAN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  output logic [DW-1:0]     dout,
  output logic              dout_vld,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [MW-1:0]     wmask,
  input  logic [DW-1:0]     di,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic [31:0]       pwrbus_ram_pd
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   r_mem [0:DEPTH-1];
  logic [DW-1:0]   w_bitmask;
  logic [DW-1:0]   w_rd_data;
  logic [DW-1:0]   r_dout;
  logic            r_vld;
  logic            w_ra_ok;
  logic            w_wa_ok;
  logic            w_idle;
  logic            w_unused;

  assign w_unused = ^pwrbus_ram_pd;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_ra_ok  = ({1'b0, ra} < DEPTH_W);
  assign w_wa_ok  = ({1'b0, wa} < DEPTH_W);
  assign clr_busy = (r_state == ST_CLEAR);

  always_comb begin
    w_bitmask = '0;
    for (int k = 0; k < MW; k++) begin
      w_bitmask[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask[k]}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage is deliberately not reset; the clear sequencer owns the port while busy.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (we && w_wa_ok) begin
      r_mem[wa] <= (r_mem[wa] & ~w_bitmask) | (di & w_bitmask);
    end
  end

  // A matching write can only hit an in-range address, so ra==wa implies wa is valid.
  always_comb begin
    w_rd_data = '0;
    if (w_idle && w_ra_ok) begin
      w_rd_data = r_mem[ra];
      if (we && (wa == ra)) begin
        w_rd_data = (r_mem[ra] & ~w_bitmask) | (di & w_bitmask);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= re;
      if (re) begin
        r_dout <= w_rd_data;
      end
    end
  end

`ifdef NV_RAM_RWS_OUT_FLOP_EN
  logic [DW-1:0] r_dout_q;
  logic          r_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_q <= '0;
      r_vld_q  <= 1'b0;
    end else begin
      r_dout_q <= r_dout;
      r_vld_q  <= r_vld;
    end
  end

  assign dout     = r_dout_q;
  assign dout_vld = r_vld_q;
`else
  assign dout     = r_dout;
  assign dout_vld = r_vld;
`endif

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// tb/tb_nv_ram_rws_param.sv - directed self-checking bench for nv_ram_rws_param
// Instance a uses DEPTH=32, instance b DEPTH=20; both share stimulus.
module tb_nv_ram_rws_param;

`ifdef NV_RAM_RWS_OUT_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ra, wa;
  logic          re, we, clr_req;
  logic [16:0]   wmask;
  logic [543:0]  di;
  logic [543:0]  dout_a, dout_b;
  logic          vld_a, vld_b, busy_a, busy_b;
  logic [31:0]   pwr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nv_ram_rws_param u_dut_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req),
    .clr_busy(busy_a), .pwrbus_ram_pd(pwr)
  );

  nv_ram_rws_param #(.DEPTH(20)) u_dut_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req),
    .clr_busy(busy_b), .pwrbus_ram_pd(pwr)
  );

  task automatic check(input string tag, input logic [543:0] got, input logic [543:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [543:0] d, input logic [16:0] m);
    we = 1'b1; wa = a; di = d; wmask = m;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [543:0] da, output logic va,
                         output logic [543:0] db, output logic vb);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    da = dout_a; va = vld_a; db = dout_b; vb = vld_b;
  endtask

  logic [543:0] rd_a, rd_b, cap_d;
  logic         rv_a, rv_b, cap_v;
  int           n_busy, n_busy_b;

  initial begin
    rst = 1'b1; re = 0; we = 0; clr_req = 0; ra = 0; wa = 0; wmask = 0; di = '0; pwr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout_a, '0);
    check("rst_vld", {543'd0, vld_a}, 544'd0);
    check("rst_busy", {543'd0, busy_a}, 544'd0);
    rst = 1'b0;
    tick();
    check("rst_dout_post", dout_a, '0);
    check("rst_busy_b", {543'd0, busy_b}, 544'd0);

    // basic write then read with hold
    do_write(5'd3, {17{32'hA5A5A5A5}}, 17'h1FFFF);
    do_read(5'd3, rd_a, rv_a, rd_b, rv_b);
    check("rd3_data", rd_a, {17{32'hA5A5A5A5}});
    check("rd3_vld", {543'd0, rv_a}, 544'd1);
    tick();
    check("hold_data", dout_a, {17{32'hA5A5A5A5}});
    check("hold_vld", {543'd0, vld_a}, 544'd0);

    // lane 0 masked write
    do_write(5'd5, {544{1'b1}}, 17'h1FFFF);
    do_write(5'd5, '0, 17'h00001);
    do_read(5'd5, rd_a, rv_a, rd_b, rv_b);
    check("mask_rd5", rd_a, {{512{1'b1}}, 32'h0});

    // same-address read during masked write
    do_write(5'd7, {17{32'h11111111}}, 17'h1FFFF);
    we = 1'b1; wa = 5'd7; di = {17{32'h22222222}}; wmask = 17'h10000;
    re = 1'b1; ra = 5'd7;
    tick();
    we = 1'b0; re = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    check("bypass", dout_a, {32'h22222222, {16{32'h11111111}}});
    do_read(5'd7, rd_a, rv_a, rd_b, rv_b);
    check("bypass_after", rd_a, {32'h22222222, {16{32'h11111111}}});

    // independent read and write at different addresses
    we = 1'b1; wa = 5'd9; di = {17{32'h0BADF00D}}; wmask = 17'h1FFFF;
    re = 1'b1; ra = 5'd3;
    tick();
    we = 1'b0; re = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    check("diff_rd3", dout_a, {17{32'hA5A5A5A5}});
    do_read(5'd9, rd_a, rv_a, rd_b, rv_b);
    check("diff_rd9", rd_a, {17{32'h0BADF00D}});

    // out of range on DEPTH=20 instance
    do_write(5'd25, {17{32'hDEADBEEF}}, 17'h1FFFF);
    do_read(5'd25, rd_a, rv_a, rd_b, rv_b);
    check("oor_data", rd_b, '0);
    check("oor_vld", {543'd0, rv_b}, 544'd1);
    do_read(5'd3, rd_a, rv_a, rd_b, rv_b);
    check("oor_keep3", rd_b, {17{32'hA5A5A5A5}});
    do_read(5'd9, rd_a, rv_a, rd_b, rv_b);
    check("oor_keep9", rd_b, {17{32'h0BADF00D}});

    // fill, then clear with a same-cycle write to entry 31
    for (int i = 0; i < 32; i++) do_write(5'(i), {17{32'(i + 1)}}, 17'h1FFFF);
    clr_req = 1'b1; we = 1'b1; wa = 5'd31; di = {544{1'b1}}; wmask = 17'h1FFFF;
    tick();
    clr_req = 1'b0; we = 1'b0;
    n_busy = 0; n_busy_b = 0; cap_d = {544{1'b1}}; cap_v = 1'b0;
    while (busy_a && n_busy < 200) begin
      n_busy++;
      n_busy_b += int'(busy_b);
      if (n_busy == 2 + LAT) begin
        cap_d = dout_a; cap_v = vld_a;
      end
      if (n_busy == 2) begin
        we = 1'b1; wa = 5'd0; di = {544{1'b1}}; wmask = 17'h1FFFF;
        re = 1'b1; ra = 5'd3;
      end else if (n_busy == 3) begin
        we = 1'b0; re = 1'b0;
      end
      tick();
    end
    check("clr_busy_cycles", 544'(n_busy), 544'd32);
    check("clr_busy_cycles_b", 544'(n_busy_b), 544'd20);
    check("clr_rd_data", cap_d, '0);
    check("clr_rd_vld", {543'd0, cap_v}, 544'd1);
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), rd_a, rv_a, rd_b, rv_b);
      check($sformatf("clr_zero_%0d", i), rd_a, '0);
    end

    // reset during an active clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    check("midclr_busy_pre", {543'd0, busy_a}, 544'd1);
    rst = 1'b1;
    #1;
    check("midclr_busy", {543'd0, busy_a}, 544'd0);
    check("midclr_busy_b", {543'd0, busy_b}, 544'd0);
    check("midclr_vld", {543'd0, vld_a}, 544'd0);
    tick();
    rst = 1'b0;
    tick();
    check("midclr_busy_post", {543'd0, busy_a}, 544'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
